// File: rtl/fetch_control_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, the NOP
// instruction loaded on reset and the default sequential PC step.
package fetch_control_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR      = 16'h0800;
  localparam logic [15:0] PC_INC_DEFAULT = 16'h0002;

endpackage

// File: rtl/fetch_control_rca_16b.sv
// 16-bit ripple-carry adder; the carry out is dropped so sums wrap mod 2^16.
module rca_16b (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum
);

  logic [15:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
    if (i < 15) begin : g_carry
      assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: owns the PC, issues reads to a variable-latency
// instruction memory and holds one instruction at a time for decode.
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_stall,
  input  logic        imem_done,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_next,
  output logic        instr_valid,
  output logic        halted,
  output logic        dump
);

  fetch_state_e r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_req_addr;
  logic         r_squash;
  logic [15:0]  r_instr;
  logic [15:0]  r_instr_pc;
  logic         r_instr_valid;
  logic         r_halted;
  logic         r_dump;

  logic [15:0]  w_req_inc;
  logic [15:0]  w_pc_next;
  logic         w_unused;

  // The request is held stable by construction, so the busy flag carries no extra information.
  assign w_unused = imem_stall;

  rca_16b u_pc_inc (
    .i_a   (r_req_addr),
    .i_b   (PC_INC),
    .i_cin (1'b0),
    .o_sum (w_req_inc)
  );

  rca_16b u_pc_next (
    .i_a   (r_instr_pc),
    .i_b   (PC_INC),
    .i_cin (1'b0),
    .o_sum (w_pc_next)
  );

  assign imem_addr   = r_req_addr;
  assign imem_rd     = (r_state == FETCH);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_next     = w_pc_next;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign dump        = r_dump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_squash      <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_dump        <= 1'b0;
    end else begin
      r_dump <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end

        FETCH: begin
          if (imem_done) begin
            if (redirect) begin
              r_pc       <= redirect_pc;
              r_req_addr <= redirect_pc;
              r_squash   <= 1'b0;
            end else if (r_squash) begin
              // Stale read from before a redirect has drained; refetch from the target.
              r_req_addr <= r_pc;
              r_squash   <= 1'b0;
            end else begin
              r_instr       <= imem_data;
              r_instr_pc    <= r_req_addr;
              r_pc          <= w_req_inc;
              r_instr_valid <= 1'b1;
              r_state       <= HOLD;
            end
          end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_squash <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect) begin
            r_pc          <= redirect_pc;
            r_req_addr    <= redirect_pc;
            r_instr_valid <= 1'b0;
            r_state       <= FETCH;
          end else if (halt) begin
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
            r_dump        <= 1'b1;
            r_state       <= HALTED;
          end else if (!stall) begin
            r_req_addr    <= r_pc;
            r_instr_valid <= 1'b0;
            r_state       <= FETCH;
          end
        end

        HALTED: begin
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_control.sv
// Randomized scoreboard bench for fetch_control with a behavioural model of
// the delivered instruction stream and a randomly-waiting memory.
module tb_fetch_control;
  import fetch_control_pkg::*;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_next;
  logic        instr_valid;
  logic        halted;
  logic        dump;

  fetch_control #(
    .RESET_PC (RESET_PC),
    .PC_INC   (16'h0002)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .imem_stall  (imem_stall),
    .imem_done   (imem_done),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_next     (pc_next),
    .instr_valid (instr_valid),
    .halted      (halted),
    .dump        (dump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur_exp;
  int          checks;
  int          failures;
  int          cyc;
  int          halt_cyc;
  int          pres_n;
  bit          mon_en;
  bit          episode0;
  bit          prev_valid;
  bit          mem_active;
  int          mem_wait;
  logic [15:0] mem_addr_q;
  logic [15:0] m_pc;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_expected();
    sb_q.push_back('{pc: m_pc, ins: mem_fn(m_pc)});
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor: pops the scoreboard on each new presentation and checks held outputs.
  always @(posedge clk) begin
    #1;
    if (mon_en && rst) begin
      if (instr_valid) begin
        if (!prev_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_delivery: got pc %h with empty scoreboard", instr_pc);
          end else begin
            cur_exp = sb_q.pop_front();
          end
          if (episode0) chk_int("zero_wait_timing", cyc, 2 + 2 * pres_n);
          pres_n++;
        end
        chk16("instr_pc", instr_pc, cur_exp.pc);
        chk16("instr", instr, cur_exp.ins);
        chk16("pc_next", pc_next, cur_exp.pc + 16'h0002);
        chk1("rd_low_in_hold", imem_rd, 1'b0);
      end
      prev_valid = instr_valid;
      chk1("dump", dump, (halt_cyc >= 0) && (cyc == halt_cyc + 1));
      chk1("halted", halted, (halt_cyc >= 0) && (cyc > halt_cyc));
      if ((halt_cyc >= 0) && (cyc > halt_cyc)) begin
        chk1("halted_rd", imem_rd, 1'b0);
        chk1("halted_valid", instr_valid, 1'b0);
      end
      if (episode0) begin
        chk1("ep0_rd_cadence", imem_rd, (cyc % 2) == 1);
        if (imem_rd) chk16("ep0_req_addr", imem_addr, 16'(cyc - 1));
      end
    end
  end

  task automatic do_reset(input bit ep0);
    @(posedge clk);
    #3;
    rst    = 1'b0;
    mon_en = 1'b0;
    #1;
    chk16("rst_instr", instr, NOP_INSTR);
    chk16("rst_instr_pc", instr_pc, RESET_PC);
    chk16("rst_pc_next", pc_next, RESET_PC + 16'h0002);
    chk16("rst_imem_addr", imem_addr, RESET_PC);
    chk1("rst_imem_rd", imem_rd, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_dump", dump, 1'b0);
    stall       = 1'b0;
    redirect    = 1'b0;
    halt        = 1'b0;
    redirect_pc = 16'h0000;
    imem_done   = 1'b0;
    imem_stall  = 1'b0;
    imem_data   = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    m_pc       = RESET_PC;
    push_expected();
    halt_cyc   = -1;
    pres_n     = 0;
    prev_valid = 1'b0;
    mem_active = 1'b0;
    episode0   = ep0;
    rst        = 1'b1;
    mon_en     = 1'b1;
  endtask

  task automatic run_episode(input int ncyc, input int halt_after);
    bit          do_redir;
    bit          do_halt;
    bit          do_stall;
    logic [15:0] tgt;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      // Memory model: random wait states, request address must not move.
      if (imem_rd) begin
        if (!mem_active) begin
          mem_active = 1'b1;
          mem_addr_q = imem_addr;
          if (episode0 || ($urandom_range(0, 9) < 4)) mem_wait = 0;
          else mem_wait = int'($urandom_range(1, 3));
        end else begin
          chk16("req_stable", imem_addr, mem_addr_q);
        end
        if (mem_wait == 0) begin
          imem_done  = 1'b1;
          imem_stall = 1'b0;
          imem_data  = mem_fn(mem_addr_q);
          mem_active = 1'b0;
        end else begin
          imem_done  = 1'b0;
          imem_stall = 1'b1;
          imem_data  = 16'hDEAD;
          mem_wait--;
        end
      end else begin
        imem_done  = 1'b0;
        imem_stall = 1'b0;
        mem_active = 1'b0;
      end

      case ($urandom_range(0, 3))
        0:       tgt = 16'hFFFE;
        1:       tgt = 16'h0100;
        default: tgt = 16'($urandom);
      endcase
      stall       = 1'b0;
      redirect    = 1'b0;
      halt        = 1'b0;
      redirect_pc = tgt;

      if (episode0) begin
        // Plain sequential fetch: every held instruction is consumed.
        if (instr_valid) begin
          m_pc = m_pc + 16'h0002;
          push_expected();
        end
      end else if (halt_cyc >= 0) begin
        stall    = ($urandom_range(0, 1) == 1);
        redirect = ($urandom_range(0, 1) == 1);
        halt     = ($urandom_range(0, 1) == 1);
      end else if (instr_valid) begin
        do_redir = ($urandom_range(0, 99) < 12);
        do_halt  = (i >= halt_after) && ($urandom_range(0, 99) < 10);
        do_stall = ($urandom_range(0, 99) < 30);
        redirect = do_redir;
        halt     = do_halt;
        stall    = do_stall;
        if (do_redir) begin
          sb_q.delete();
          m_pc = tgt;
          push_expected();
        end else if (do_halt) begin
          halt_cyc = cyc;
        end else if (!do_stall) begin
          m_pc = m_pc + 16'h0002;
          push_expected();
        end
      end else if (imem_rd) begin
        do_redir = ($urandom_range(0, 99) < 8);
        redirect = do_redir;
        halt     = ($urandom_range(0, 1) == 1);
        stall    = ($urandom_range(0, 1) == 1);
        if (do_redir) begin
          sb_q.delete();
          m_pc = tgt;
          push_expected();
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    halt_cyc    = -1;
    mon_en      = 1'b0;
    episode0    = 1'b0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    halt        = 1'b0;
    redirect_pc = 16'h0000;
    imem_done   = 1'b0;
    imem_stall  = 1'b0;
    imem_data   = 16'h0000;
    m_pc        = RESET_PC;

    do_reset(1'b1);
    run_episode(10, 0);
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(1'b0);
      run_episode(400, 250);
    end
    do_reset(1'b0);
    run_episode(3, 1000);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
